cpu_id_hazard: RTL
==================

CPU_ID_HAZARD -- requirements
Module: cpu_id_hazard

Interface
REQ-001 Parameter NUM_FWD, 2, number of forwarding channels; channel 0 is the youngest pipeline stage.
REQ-002 Parameter LOAD_LAT, 1, cycles after a load issues before its data appears on a forwarding channel; legal range 1..7.
REQ-003 clk  in  1  clock; the block uses one clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 flush  in  1  pipeline flush; clears all pending-load state.
REQ-006 stall_ext  in  1  downstream stall; the ID stage and the scoreboard hold.
REQ-007 id_valid  in  1  a valid instruction is present in ID.
REQ-008 raddr1, raddr2  in  5 each  source register addresses.
REQ-009 rdata1_i, rdata2_i  in  32 each  register-file read data.
REQ-010 issue_we, issue_is_load  in  1 each  the ID instruction writes a register / is a load.
REQ-011 issue_waddr  in  5  destination register of the ID instruction.
REQ-012 fwd_we  in  NUM_FWD  per-channel write enable.
REQ-013 fwd_waddr  in  NUM_FWD*5  per-channel write address; channel k occupies bits [5k+4:5k].
REQ-014 fwd_wdata  in  NUM_FWD*32  per-channel write data; channel k occupies bits [32k+31:32k].
REQ-015 reg1_o, reg2_o  out  32 each  hazard-safe operand values.
REQ-016 stall_req  out  1  ID must stall because of a load-use hazard.
REQ-017 issue_fire  out  1  the ID instruction leaves ID this cycle.
REQ-018 busy_mask  out  32  bit i is set while register i has a pending load.

Function
REQ-019 The block shall hold one countdown counter per register, 1..31; each counter is 3 bits wide. Register 0 has no counter, and busy_mask[0] shall always be 0.
REQ-020 busy_mask[i] shall equal (cnt[i] != 0). It is combinational from the registered counters.
REQ-021 Operand selection for operand n (n = 1, 2):
  - If raddrn == 0, the operand is 0.
  - Otherwise, if some channel k has fwd_we[k] set and fwd_waddr[k] == raddrn, the operand is the data of the lowest such k.
  - Otherwise, the operand is rdatan_i.
  - This logic is purely combinational.
REQ-022 stall_req shall equal id_valid AND ((raddr1 != 0 AND cnt[raddr1] != 0) OR (raddr2 != 0 AND cnt[raddr2] != 0)). It is combinational, with zero-cycle latency.
REQ-023 issue_fire shall equal id_valid AND NOT stall_req AND NOT stall_ext.
REQ-024 Counter update at each rising clk edge, in priority order:
  - rst: all counters become 0.
  - else flush: all counters become 0, and any issue this cycle is ignored.
  - else stall_ext: all counters hold.
  - else: every non-zero counter decrements by 1.
REQ-025 On an issue_fire cycle without flush, with issue_we=1 and issue_waddr != 0:
  - issue_is_load=1: cnt[issue_waddr] shall load LOAD_LAT. This overrides the decrement for that entry.
  - issue_is_load=0: cnt[issue_waddr] shall become 0, because the younger ALU write supersedes the pending load.
REQ-026 Writes with issue_waddr == 0, and issues with issue_we=0, shall leave all counters unaffected apart from the normal decrement.
REQ-027 Counters shall never wrap: a counter at 0 stays at 0.
REQ-028 A stalled instruction shall re-evaluate stall_req every cycle. It shall proceed in the first cycle in which both of its source counters read 0.
REQ-029 Several loads may be pending at once to different registers. Each register's counter is independent.

Reset
REQ-030 While rst=1, all counters shall be 0 at the next edge. stall_req, issue_fire and busy_mask then follow combinationally: busy_mask=0 and stall_req=0.
REQ-031 A reset or flush asserted while loads are pending shall clear them all. No stall shall be requested in the cycle that follows.

Verification
REQ-032 LOAD_LAT=1: issue a load to $5. Next cycle, present a consumer with raddr1=5 and fwd0 = {we=1, waddr=5, wdata=0xDEADBEEF}.
  - Cycle 1: stall_req=1 and busy_mask=0x20.
  - Cycle 2: stall_req=0 and reg1_o=0xDEADBEEF.
REQ-033 LOAD_LAT=3: load to $7, followed by a consumer of $7 → stall_req=1 for exactly 3 cycles, then issue_fire=1.
REQ-034 Pending load to $4 (cnt=2), then flush=1 → busy_mask=0 next cycle and stall_req=0 for a $4 consumer.
REQ-035 raddr1=9 with fwd0 = {9, 0x11} and fwd1 = {9, 0x22} → reg1_o=0x11. With raddr1=0 and a channel writing $0 → reg1_o=0.
REQ-036 Pending load to $3 (cnt=2), then an ALU issue writing $3 → cnt[3]=0 next cycle. With stall_ext=1 held 4 cycles on another pending load, that counter stays unchanged.

Source files
------------

// File: rtl/cpu_id_hazard.sv
// ID-stage load-use hazard unit.
// Keeps a small countdown per architectural register that marks a load whose
// data has not yet reached a forwarding channel. Operand values come from the
// youngest forwarding channel that writes the source register, or otherwise
// from the register file.
module cpu_id_hazard #(
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall_ext,
    input  logic                    id_valid,
    input  logic [4:0]              raddr1,
    input  logic [4:0]              raddr2,
    input  logic [31:0]             rdata1_i,
    input  logic [31:0]             rdata2_i,
    input  logic                    issue_we,
    input  logic                    issue_is_load,
    input  logic [4:0]              issue_waddr,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*5-1:0]    fwd_waddr,
    input  logic [NUM_FWD*32-1:0]   fwd_wdata,
    output logic [31:0]             reg1_o,
    output logic [31:0]             reg2_o,
    output logic                    stall_req,
    output logic                    issue_fire,
    output logic [31:0]             busy_mask
);

    localparam logic [2:0] LAT = 3'(LOAD_LAT);

    // Operand select: register 0 reads as zero, then the lowest-numbered
    // (youngest) matching forwarding channel, then the register file.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]            addr,
        input logic [31:0]           rf_data,
        input logic [NUM_FWD-1:0]    we,
        input logic [NUM_FWD*5-1:0]  waddr,
        input logic [NUM_FWD*32-1:0] wdata
    );
        logic [31:0] sel;
        sel = rf_data;
        // Walk from oldest to youngest so the youngest match is written last.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (we[k] && (waddr[5*k +: 5] == addr)) begin
                sel = wdata[32*k +: 32];
            end
        end
        if (addr == 5'd0) begin
            sel = '0;
        end
        return sel;
    endfunction

    // Hazard-safe operand values.
    always_comb begin
        reg1_o = fwd_select(raddr1, rdata1_i, fwd_we, fwd_waddr, fwd_wdata);
        reg2_o = fwd_select(raddr2, rdata2_i, fwd_we, fwd_waddr, fwd_wdata);
    end

    // Load-use stall and issue decision; busy_mask[0] is constant zero so the
    // lookups below already treat $0 as never pending.
    always_comb begin
        stall_req  = id_valid &&
                     (((raddr1 != 5'd0) && busy_mask[raddr1]) ||
                      ((raddr2 != 5'd0) && busy_mask[raddr2]));
        issue_fire = id_valid && !stall_req && !stall_ext;
    end

    assign busy_mask[0] = 1'b0;

    // One pending-load countdown per register $1..$31.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
            logic [2:0] cnt_reg;
            logic [2:0] cnt_next;
            logic       hit;

            assign hit = issue_fire && issue_we && (issue_waddr == 5'(gi));

            // Next count: flush clears, external stall holds, otherwise count
            // down; a new issue to this register overrides the countdown
            // (a load re-arms it, an ALU write supersedes the pending load).
            always_comb begin
                cnt_next = cnt_reg;
                if (flush) begin
                    cnt_next = '0;
                end else if (!stall_ext) begin
                    if (cnt_reg != 3'd0) begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                    if (hit) begin
                        cnt_next = issue_is_load ? LAT : 3'd0;
                    end
                end
            end

            // Counter register with synchronous reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign busy_mask[gi] = (cnt_reg != 3'd0);
        end
    endgenerate

endmodule
